// File: rtl/apb_i2c_master_ctrl.sv
// APB requester for the I2C bridge register file: one command at a time, SETUP/ACCESS, PREADY wait.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_i2c_master_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept;
  logic              wr_addr_ok;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

  // cmd_ready_q is only ever set while IDLE, so it alone qualifies acceptance
  assign accept     = cmd_valid && cmd_ready_q;
  assign wr_addr_ok = (cmd_addr == ADDR_W'(0)) || (cmd_addr == ADDR_W'(1)) ||
                      (cmd_addr == ADDR_W'(2)) || (cmd_addr == ADDR_W'(4));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_write && !wr_addr_ok) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
